// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM state encoding and counter width.
package spi_pkg;

    typedef enum logic [1:0] {
        S_ARM,
        S_IDLE,
        S_ACTIVE
    } spi_state_e;

    function automatic int unsigned cnt_width(input int unsigned maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin plus rise/fall detection on the synced level.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic sreset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (sreset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_drv.sv
// SPI mode-0 responder: oversampled SCLK/SS_N/MOSI, MSB-first RX capture and TX reply shifting,
// with a single-word TX buffer behind a valid/ready load port.
module spi_slave_drv
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MAXLEN  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               sreset,
    input  logic [SPI_MAXLEN-1:0]              tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic [SPI_MAXLEN-1:0]              rx_data,
    output logic [cnt_width(SPI_MAXLEN)-1:0]   rx_nbits,
    output logic                               rx_valid,
    output logic                               tx_underrun,
    output logic                               rx_overrun,
    output logic                               busy,
    input  logic                               SCLK,
    input  logic                               MOSI,
    input  logic                               SS_N,
    output logic                               MISO,
    output logic                               MISO_OE
);

    localparam int unsigned     CW       = cnt_width(SPI_MAXLEN);
    localparam int unsigned     AW       = $clog2(SYNC_STAGES + 2);
    localparam logic [AW-1:0]   ARM_WAIT = AW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(SPI_MAXLEN);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk      (clk),
        .sreset   (sreset),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .sreset   (sreset),
        .async_in (SS_N),
        .level    (ss_level),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk      (clk),
        .sreset   (sreset),
        .async_in (MOSI),
        .level    (mosi_sync),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    spi_state_e            state_q;
    logic [AW-1:0]         arm_cnt_q;
    logic [SPI_MAXLEN-1:0] tx_buf_q;
    logic                  tx_full_q;
    logic [SPI_MAXLEN-1:0] shreg_q;
    logic [SPI_MAXLEN-1:0] rx_shreg_q;
    logic [CW-1:0]         cnt_q;
    logic [SPI_MAXLEN-1:0] rx_data_q;
    logic [CW-1:0]         rx_nbits_q;
    logic                  rx_valid_q;
    logic                  tx_underrun_q;
    logic                  rx_overrun_q;
    logic                  miso_q;
    logic                  miso_oe_q;

    logic                  tx_load;
    logic [SPI_MAXLEN-1:0] rx_shreg_d;
    logic [CW-1:0]         cnt_d;
    logic                  ovf;

    assign tx_load = tx_valid && !tx_full_q;

    // Bit sampled on this clk's rise is folded in before a coincident frame close.
    always_comb begin
        rx_shreg_d = rx_shreg_q;
        cnt_d      = cnt_q;
        ovf        = 1'b0;
        if (sclk_rise) begin
            rx_shreg_d = {rx_shreg_q[SPI_MAXLEN-2:0], mosi_sync};
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q       <= S_ARM;
            arm_cnt_q     <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            shreg_q       <= '0;
            rx_shreg_q    <= '0;
            cnt_q         <= '0;
            rx_data_q     <= '0;
            rx_nbits_q    <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_load) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end
            unique case (state_q)
                // Let the synchronizer flush before trusting SS_N, so a frame already
                // underway at reset is skipped rather than joined mid-stream.
                S_ARM: begin
                    if (arm_cnt_q != ARM_WAIT) begin
                        arm_cnt_q <= arm_cnt_q + 1'b1;
                    end else if (ss_level) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (ss_fall) begin
                        if (tx_full_q) begin
                            shreg_q   <= tx_buf_q;
                            miso_q    <= tx_buf_q[SPI_MAXLEN-1];
                            tx_full_q <= 1'b0;
                        end else if (tx_load) begin
                            shreg_q   <= tx_data;
                            miso_q    <= tx_data[SPI_MAXLEN-1];
                            tx_full_q <= 1'b0;
                        end else begin
                            shreg_q       <= '0;
                            miso_q        <= 1'b0;
                            tx_underrun_q <= 1'b1;
                        end
                        rx_shreg_q <= '0;
                        cnt_q      <= '0;
                        miso_oe_q  <= 1'b1;
                        state_q    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    rx_shreg_q <= rx_shreg_d;
                    cnt_q      <= cnt_d;
                    if (ovf) begin
                        rx_overrun_q <= 1'b1;
                    end
                    if (sclk_fall) begin
                        shreg_q <= shreg_q << 1;
                        miso_q  <= shreg_q[SPI_MAXLEN-2];
                    end
                    if (ss_rise) begin
                        rx_data_q  <= rx_shreg_d;
                        rx_nbits_q <= cnt_d;
                        rx_valid_q <= (cnt_d != '0);
                        miso_q     <= 1'b0;
                        miso_oe_q  <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_ARM;
            endcase
        end
    end

    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_nbits    = rx_nbits_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_overrun  = rx_overrun_q;
    assign busy        = (state_q == S_ACTIVE);
    assign MISO        = miso_q;
    assign MISO_OE     = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_drv.sv
// Randomized scoreboard bench for spi_slave_drv: a bus-level SPI master model drives frames,
// expected RX words are queued and checked by an independent monitor on rx_valid.
module tb_spi_slave_drv;

    localparam int unsigned MAXLEN = 32;
    localparam int unsigned NW     = $clog2(MAXLEN) + 1;
    localparam int unsigned SYNC   = 2;

    logic              clk = 1'b0;
    logic              sreset;
    logic [MAXLEN-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [MAXLEN-1:0] rx_data;
    logic [NW-1:0]     rx_nbits;
    logic              rx_valid;
    logic              tx_underrun;
    logic              rx_overrun;
    logic              busy;
    logic              SCLK;
    logic              MOSI;
    logic              SS_N;
    logic              MISO;
    logic              MISO_OE;

    always #5 clk = ~clk;

    spi_slave_drv #(.SPI_MAXLEN(MAXLEN), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .sreset      (sreset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_nbits    (rx_nbits),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .rx_overrun  (rx_overrun),
        .busy        (busy),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .SS_N        (SS_N),
        .MISO        (MISO),
        .MISO_OE     (MISO_OE)
    );

    typedef struct packed {
        logic [MAXLEN-1:0] data;
        logic [NW-1:0]     nbits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state of the responder as seen from outside.
    logic        m_full;
    logic [31:0] m_buf;
    logic        m_underrun;
    logic        m_overrun;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sreset === 1'b0 && rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_valid: got rx_data 0x%0h nbits %0d expected none",
                         rx_data, rx_nbits);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {32'h0, rx_data}, {32'h0, e.data});
                check("rx_nbits", {58'h0, rx_nbits}, {58'h0, e.nbits});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        sreset = 1'b1;
        repeat (3) @(negedge clk);
        sreset = 1'b0;
        m_full     = 1'b0;
        m_underrun = 1'b0;
        m_overrun  = 1'b0;
    endtask

    task automatic load_tx(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got tx_ready %b expected 1", tx_ready);
        end else begin
            tx_data  = w;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            m_buf  = w;
            m_full = 1'b1;
        end
    endtask

    task automatic sclk_pulses(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            MOSI = 1'($urandom);
            repeat (half) @(negedge clk);
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nbits, input logic [63:0] mosi_w, input int half,
                             input bit mid_load, input logic [31:0] mid_word);
        logic [31:0] reply;
        logic [63:0] got;
        logic [63:0] want;
        logic [63:0] mask;
        exp_t        e;
        reply = m_full ? m_buf : 32'h0;
        if (!m_full) m_underrun = 1'b1;
        m_full = 1'b0;
        if (nbits > 32) m_overrun = 1'b1;
        got  = '0;
        want = '0;
        SS_N = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_w[nbits-1-i];
            repeat (half) @(negedge clk);
            SCLK = 1'b1;
            got = {got[62:0], MISO};
            want = {want[62:0], (i < 32) ? reply[31-i] : 1'b0};
            if (i == 0) begin
                check("busy_in_frame", {63'h0, busy}, 64'd1);
                check("miso_oe_in_frame", {63'h0, MISO_OE}, 64'd1);
            end
            repeat (half) @(negedge clk);
            SCLK = 1'b0;
            if (i == 0 && mid_load) load_tx(mid_word);
        end
        repeat (half) @(negedge clk);
        SS_N = 1'b1;
        if (nbits > 0) begin
            mask    = (nbits >= 32) ? 64'hFFFF_FFFF : ((64'd1 << nbits) - 64'd1);
            e.data  = 32'(mosi_w & mask);
            e.nbits = NW'((nbits > 32) ? 32 : nbits);
            exp_q.push_back(e);
        end
        check("miso_stream", got, want);
        repeat (2 * SYNC + 8) @(negedge clk);
        check("busy_after", {63'h0, busy}, 64'd0);
        check("miso_oe_after", {63'h0, MISO_OE}, 64'd0);
        check("miso_after", {63'h0, MISO}, 64'd0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_tx_underrun"}, {63'h0, tx_underrun}, {63'h0, m_underrun});
        check({tag, "_rx_overrun"}, {63'h0, rx_overrun}, {63'h0, m_overrun});
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] w;
        sreset   = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        SS_N     = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        check("rst_tx_ready", {63'h0, tx_ready}, 64'd1);
        check("rst_rx_data", {32'h0, rx_data}, 64'd0);
        check("rst_rx_nbits", {58'h0, rx_nbits}, 64'd0);
        check("rst_rx_valid", {63'h0, rx_valid}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        check("rst_miso", {63'h0, MISO}, 64'd0);
        check("rst_miso_oe", {63'h0, MISO_OE}, 64'd0);
        check_flags("rst");
        repeat (10) @(negedge clk);

        // Full 32-bit frame at a slow clock ratio.
        load_tx(32'hA5A5_F00F);
        spi_frame(32, 64'h1234_5678, 50, 1'b0, 32'h0);
        // Short 8-bit frame.
        load_tx(32'h9600_0000);
        spi_frame(8, 64'hC3, 10, 1'b0, 32'h0);
        check_flags("short");

        // SS_N pulse without SCLK consumes the buffer and reports nothing.
        load_tx(32'hDEAD_BEEF);
        check("tx_ready_loaded", {63'h0, tx_ready}, 64'd0);
        spi_frame(0, 64'h0, 8, 1'b0, 32'h0);
        check("tx_ready_after_pulse", {63'h0, tx_ready}, 64'd1);

        // Back-to-back frames, each loading the next reply mid-frame.
        load_tx(32'h1111_2222);
        spi_frame(16, 64'hBEEF, 8, 1'b1, 32'h3333_4444);
        spi_frame(24, 64'h00AB_CDEF, 7, 1'b1, 32'h8765_4321);
        spi_frame(32, 64'hCAFE_F00D, 6, 1'b0, 32'h0);
        check_flags("b2b");

        for (int k = 0; k < 6; k++) begin
            w = $urandom;
            load_tx(w);
            spi_frame(int'($urandom_range(1, 32)), {32'($urandom), 32'($urandom)},
                      int'($urandom_range(6, 14)), 1'b0, 32'h0);
        end
        check_flags("rand");

        // Frame with no reply loaded.
        spi_frame(12, 64'hA5C, 8, 1'b0, 32'h0);
        check_flags("underrun");

        // 40 SCLK pulses overflow the capture window.
        load_tx(32'h0F0F_0F0F);
        spi_frame(40, {32'($urandom), 32'($urandom)}, 6, 1'b0, 32'h0);
        check_flags("overrun");

        // Reset in the middle of a frame, SS_N held low across it.
        load_tx(32'h5555_AAAA);
        SS_N = 1'b0;
        repeat (8) @(negedge clk);
        sclk_pulses(10, 7);
        do_reset();
        sclk_pulses(5, 7);
        check("busy_armed", {63'h0, busy}, 64'd0);
        check("miso_oe_armed", {63'h0, MISO_OE}, 64'd0);
        SS_N = 1'b1;
        repeat (12) @(negedge clk);
        check("tx_ready_post_rst", {63'h0, tx_ready}, 64'd1);
        check_flags("post_rst");
        load_tx(32'h7E57_0001);
        spi_frame(20, 64'h9_3C5A, 8, 1'b0, 32'h0);
        check_flags("final");

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
